plb_cache: RTL and testbench
============================

PLB_CACHE -- requirements
Module: plb_cache

Interface
REQ-001 SHALL have parameter PLB_ENTRIES, default 4, giving the number of fully-associative entries (legal range 2..16).
REQ-002 SHALL have parameter PLB_DATA_WIDTH, default 64, giving the lookup response width.
REQ-003 SHALL have parameter PLB_ADDR_WIDTH, default 64, giving the width of the packed lookup tag.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port plb_slave_mem_req, input, 1 bit: lookup request.
REQ-007 SHALL have port plb_slave_mem_gnt, output, 1 bit: request accepted.
REQ-008 SHALL have port plb_slave_mem_valid, output, 1 bit: response valid.
REQ-009 SHALL have port plb_slave_mem_addr, input, PLB_ADDR_WIDTH bits: packed lookup tag (SDID, SPA page, access type).
REQ-010 SHALL have port plb_slave_mem_rdata, output, PLB_DATA_WIDTH bits: entry data on a hit, 0 on a miss.
REQ-011 SHALL have ports plb_slave_mem_wdata (PLB_DATA_WIDTH bits), plb_slave_mem_we (1 bit) and plb_slave_mem_be (PLB_DATA_WIDTH/8 bits), all inputs: write side, never legal.
REQ-012 SHALL have port plb_slave_mem_error, output, 1 bit: response error.
REQ-013 SHALL have fill ports: fill_valid_i (input, 1 bit), fill_ready_o (output, 1 bit), fill_tag_i (input, PLB_ADDR_WIDTH bits) and fill_data_i (input, PLB_DATA_WIDTH bits).
REQ-014 SHALL have port flush_i, input, 1 bit: invalidate all entries.

Function
REQ-015 SHALL tie plb_slave_mem_gnt to 1, so a request is accepted whenever req is 1; one lookup is handled per cycle.
REQ-016 SHALL compare the tag against all valid entries in the accept cycle and register the result.
REQ-017 SHALL assert valid exactly 1 cycle after the accept cycle, for 1 cycle, with full pipelining.
REQ-018 On a hit, rdata SHALL be the matching entry data; on a miss, rdata SHALL be 0; in both cases error SHALL be 0.
REQ-019 An accepted request with we=1 SHALL produce valid with error=1 and rdata=0, and SHALL leave the contents unchanged.
REQ-020 SHALL hold fill_ready_o at 1 except in a flush cycle; a fill takes effect at the clock edge of the fill_valid_i && fill_ready_o cycle.
REQ-021 If fill_tag_i matches a valid entry, the fill SHALL overwrite that entry and SHALL NOT advance the victim pointer.
REQ-022 Otherwise the fill SHALL write the entry at the round-robin victim pointer and set it valid; the pointer SHALL increment and wrap from PLB_ENTRIES-1 to 0.
REQ-023 A fill with fill_data_i == 0 SHALL be accepted and discarded, because 0 encodes a miss.
REQ-024 A lookup and a fill in the same cycle SHALL see the pre-fill contents.
REQ-025 A lookup and a flush in the same cycle SHALL see the pre-flush contents.
REQ-026 A flush SHALL clear all valid bits and reset the pointer to 0 at the next edge; flush takes priority over a same-cycle fill, which is dropped.
REQ-027 A response whose request was accepted before a flush SHALL still be delivered.

Reset
REQ-028 While rst_ni=0, SHALL force valid=0, error=0, rdata=0, gnt=1, fill_ready_o=1, all valid bits clear and the pointer at 0.
REQ-029 A reset asserted between accept and response SHALL drop that response.

Configuration
REQ-030 With PLB_STATS_EN defined, SHALL add outputs hit_count_o and miss_count_o (32 bits each), which increment on each error-free response, saturate at 0xFFFFFFFF, reset to 0 and are not cleared by flush.
REQ-031 Without PLB_STATS_EN, SHALL have no counter ports and no counter logic.

Structure
REQ-032 SHALL place plb_entry_t (valid, tag, data) and PLB_DEFAULT_ENTRIES in mpt_pkg.
REQ-033 SHALL be a single module with no sub-module; the entry array, comparators and victim pointer are inline.

Verification
REQ-034 Empty cache, lookup tag 0x10 -> valid 1 cycle later, rdata=0, error=0.
REQ-035 Fill tag 0x10 with data 0xAB, then lookup 0x10 -> rdata=0xAB; back-to-back lookups 0x10, 0x20 -> rdata 0xAB then 0 on consecutive cycles.
REQ-036 PLB_ENTRIES=4, fill tags 1..5 -> tag 1 misses, tags 2..5 hit; refill of tag 3 with 0xCC leaves the pointer unchanged.
REQ-037 Same-cycle fill 0x30 and lookup 0x30 -> miss; lookup one cycle later -> hit.
REQ-038 Flush concurrent with fill 0x40 and lookup of resident 0x10 -> lookup hits, 0x40 absent, all later lookups miss.
REQ-039 Lookup with we=1 -> error=1, rdata=0; with PLB_STATS_EN defined, counters unchanged.

Source files
------------

// File: rtl/mpt_pkg.sv
// Shared types for the PLB lookup cache: one entry record plus default sizing.
// Tag and data fields are stored at their maximum width; narrower builds zero-extend.
package mpt_pkg;

   localparam int PLB_DEFAULT_ENTRIES = 4;
   localparam int PLB_MAX_TAG_WIDTH   = 64;
   localparam int PLB_MAX_DATA_WIDTH  = 64;

   typedef struct packed {
      logic                          valid;
      logic [PLB_MAX_TAG_WIDTH-1:0]  tag;
      logic [PLB_MAX_DATA_WIDTH-1:0] data;
   } plb_entry_t;

endpackage

// File: rtl/plb_cache.sv
// Fully-associative lookup cache with round-robin fill and one-cycle registered response.
// Optional hit/miss counters are built when PLB_STATS_EN is defined.
module plb_cache
   import mpt_pkg::*;
#(
   parameter int PLB_ENTRIES    = PLB_DEFAULT_ENTRIES,
   parameter int PLB_DATA_WIDTH = 64,
   parameter int PLB_ADDR_WIDTH = 64
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        plb_slave_mem_req,
   output logic                        plb_slave_mem_gnt,
   output logic                        plb_slave_mem_valid,
   input  logic [PLB_ADDR_WIDTH-1:0]   plb_slave_mem_addr,
   output logic [PLB_DATA_WIDTH-1:0]   plb_slave_mem_rdata,
   input  logic [PLB_DATA_WIDTH-1:0]   plb_slave_mem_wdata,
   input  logic                        plb_slave_mem_we,
   input  logic [PLB_DATA_WIDTH/8-1:0] plb_slave_mem_be,
   output logic                        plb_slave_mem_error,
   input  logic                        fill_valid_i,
   output logic                        fill_ready_o,
   input  logic [PLB_ADDR_WIDTH-1:0]   fill_tag_i,
   input  logic [PLB_DATA_WIDTH-1:0]   fill_data_i,
`ifdef PLB_STATS_EN
   output logic [31:0]                 hit_count_o,
   output logic [31:0]                 miss_count_o,
`endif
   input  logic                        flush_i
);

   localparam int PTR_W = $clog2(PLB_ENTRIES);

   plb_entry_t                    entries_q [PLB_ENTRIES];
   logic [PTR_W-1:0]              ptr_q;
   logic [PLB_ENTRIES-1:0]        lookup_hit;
   logic [PLB_ENTRIES-1:0]        fill_hit;
   logic [PTR_W-1:0]              fill_idx;
   logic [PLB_MAX_DATA_WIDTH-1:0] hit_data;
   logic [PLB_MAX_TAG_WIDTH-1:0]  lookup_tag;
   logic [PLB_MAX_TAG_WIDTH-1:0]  fill_tag;
   logic [PLB_MAX_DATA_WIDTH-1:0] fill_data;
   logic                          fill_fire;
   logic                          lookup_ok;
   logic                          resp_valid_q;
   logic                          resp_error_q;
   logic [PLB_DATA_WIDTH-1:0]     resp_rdata_q;
   logic                          unused_ok;

   // The write side exists only to be rejected; its payload is never stored.
   assign unused_ok = ^{plb_slave_mem_wdata, plb_slave_mem_be};

   assign lookup_tag = PLB_MAX_TAG_WIDTH'(plb_slave_mem_addr);
   assign fill_tag   = PLB_MAX_TAG_WIDTH'(fill_tag_i);
   assign fill_data  = PLB_MAX_DATA_WIDTH'(fill_data_i);

   assign plb_slave_mem_gnt = 1'b1;
   assign fill_ready_o      = !flush_i || !rst_ni;
   // Zero data is the miss encoding, so such a fill is taken but never stored.
   assign fill_fire         = fill_valid_i && fill_ready_o && (fill_data_i != '0);
   assign lookup_ok         = plb_slave_mem_req && !plb_slave_mem_we;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      lookup_hit = '0;
      fill_hit   = '0;
      fill_idx   = '0;
      hit_data   = '0;
      for (int i = 0; i < PLB_ENTRIES; i++) begin
         lookup_hit[i] = entries_q[i].valid && (entries_q[i].tag == lookup_tag);
         fill_hit[i]   = entries_q[i].valid && (entries_q[i].tag == fill_tag);
         if (lookup_hit[i]) hit_data = hit_data | entries_q[i].data;
         if (fill_hit[i])   fill_idx = PTR_W'(i);
      end
   end

   // NOTE: the entry array is small, so it is fully reset and no X can reach a comparator.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < PLB_ENTRIES; i++) entries_q[i] <= '0;
         ptr_q <= '0;
      end else if (flush_i) begin
         for (int i = 0; i < PLB_ENTRIES; i++) entries_q[i].valid <= 1'b0;
         ptr_q <= '0;
      end else if (fill_fire) begin
         if (|fill_hit) begin
            entries_q[fill_idx].data <= fill_data;
         end else begin
            entries_q[ptr_q] <= '{valid: 1'b1, tag: fill_tag, data: fill_data};
            ptr_q <= (ptr_q == PTR_W'(PLB_ENTRIES - 1)) ? '0 : ptr_q + PTR_W'(1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample together.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         resp_valid_q <= plb_slave_mem_req;
         resp_error_q <= plb_slave_mem_req && plb_slave_mem_we;
         resp_rdata_q <= lookup_ok ? hit_data[PLB_DATA_WIDTH-1:0] : '0;
      end
   end

   assign plb_slave_mem_valid = resp_valid_q;
   assign plb_slave_mem_error = resp_error_q;
   assign plb_slave_mem_rdata = resp_rdata_q;

`ifdef PLB_STATS_EN
   logic [31:0] hit_count_q;
   logic [31:0] miss_count_q;

   // Counters move on the accept edge, together with the response they describe.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else if (lookup_ok) begin
         if (|lookup_hit) begin
            if (hit_count_q != '1) hit_count_q <= hit_count_q + 32'd1;
         end else begin
            if (miss_count_q != '1) miss_count_q <= miss_count_q + 32'd1;
         end
      end
   end

   assign hit_count_o  = hit_count_q;
   assign miss_count_o = miss_count_q;
`endif

endmodule

// File: tb/tb_plb_cache.sv
// Bench for plb_cache: expected responses are queued when a request is accepted and
// compared on the falling edge of the response cycle. Honours PLB_STATS_EN.
module tb_plb_cache;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, we, fill_valid, flush;
   logic [63:0] addr, wdata, fill_tag, fill_data;
   logic [7:0]  be;
   logic        gnt, valid, error, fill_ready;
   logic [63:0] rdata;
`ifdef PLB_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   typedef struct {
      logic [63:0] data;
      logic        err;
   } exp_t;

   exp_t        q[$];
   exp_t        staged;
   bit          staged_v;
   int          vectors;
   int          miscompares;
   int unsigned exp_hits;
   int unsigned exp_misses;

   always #5 clk = ~clk;

   plb_cache dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .plb_slave_mem_req  (req),
      .plb_slave_mem_gnt  (gnt),
      .plb_slave_mem_valid(valid),
      .plb_slave_mem_addr (addr),
      .plb_slave_mem_rdata(rdata),
      .plb_slave_mem_wdata(wdata),
      .plb_slave_mem_we   (we),
      .plb_slave_mem_be   (be),
      .plb_slave_mem_error(error),
      .fill_valid_i       (fill_valid),
      .fill_ready_o       (fill_ready),
      .fill_tag_i         (fill_tag),
      .fill_data_i        (fill_data),
`ifdef PLB_STATS_EN
      .hit_count_o        (hit_count),
      .miss_count_o       (miss_count),
`endif
      .flush_i            (flush)
   );

   // Response checker: a queued expectation must appear exactly in this cycle.
   always @(negedge clk) begin
      exp_t e;
      vectors++;
      if (q.size() > 0) begin
         e = q.pop_front();
         if (valid !== 1'b1 || rdata !== e.data || error !== e.err) begin
            miscompares++;
            $display("FAIL resp: got valid=%b rdata=%h error=%b, want valid=1 rdata=%h error=%b",
                     valid, rdata, error, e.data, e.err);
         end
      end else if (valid !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_valid: got valid=%b, want 0", valid);
      end
   end

   task automatic step();
      @(posedge clk);
      if (staged_v && rst_n) begin
         q.push_back(staged);
         if (!staged.err) begin
            if (staged.data != 64'd0) exp_hits++;
            else                      exp_misses++;
         end
      end
      staged_v = 1'b0;
      #1;
      req        = 1'b0;
      we         = 1'b0;
      addr       = '0;
      wdata      = '0;
      fill_valid = 1'b0;
      fill_tag   = '0;
      fill_data  = '0;
      flush      = 1'b0;
   endtask

   task automatic issue(input logic [63:0] tag, input logic is_we,
                        input logic [63:0] exp_data, input logic exp_err);
      req      = 1'b1;
      addr     = tag;
      we       = is_we;
      wdata    = is_we ? 64'hDEAD_BEEF : 64'd0;
      staged   = '{exp_data, exp_err};
      staged_v = 1'b1;
   endtask

   task automatic fill(input logic [63:0] tag, input logic [63:0] data);
      fill_valid = 1'b1;
      fill_tag   = tag;
      fill_data  = data;
   endtask

   task automatic lookup_step(input logic [63:0] tag, input logic [63:0] exp_data);
      issue(tag, 1'b0, exp_data, 1'b0);
      step();
   endtask

   task automatic fill_step(input logic [63:0] tag, input logic [63:0] data);
      fill(tag, data);
      step();
   endtask

   task automatic flush_step();
      flush = 1'b1;
      #1;
      vectors++;
      if (fill_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_ready: got fill_ready=%b, want 0", fill_ready);
      end
      step();
   endtask

   task automatic check_stats(input string name);
`ifdef PLB_STATS_EN
      vectors++;
      if (hit_count !== exp_hits || miss_count !== exp_misses) begin
         miscompares++;
         $display("FAIL %s: got hits=%0d misses=%0d, want hits=%0d misses=%0d",
                  name, hit_count, miss_count, exp_hits, exp_misses);
      end
`else
      vectors = vectors + (name.len() > 0 ? 0 : 0);
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 1'b1;
      flush = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (valid !== 1'b0 || error !== 1'b0 || rdata !== 64'd0 || gnt !== 1'b1 || fill_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_outputs: got valid=%b error=%b rdata=%h gnt=%b fill_ready=%b, want 0 0 0 1 1",
                  valid, error, rdata, gnt, fill_ready);
      end
      req   = 1'b0;
      flush = 1'b0;
      rst_n = 1'b1;
      exp_hits   = 0;
      exp_misses = 0;
      #1;
      vectors++;
      if (gnt !== 1'b1 || fill_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL idle_ready: got gnt=%b fill_ready=%b, want 1 1", gnt, fill_ready);
      end
      step();
   endtask

   task automatic test_miss_empty();
      lookup_step(64'h10, 64'd0);
   endtask

   task automatic test_hit();
      fill_step(64'h10, 64'hAB);
      lookup_step(64'h10, 64'hAB);
      lookup_step(64'h10, 64'hAB);
      lookup_step(64'h20, 64'd0);
   endtask

   task automatic test_round_robin();
      flush_step();
      for (int t = 1; t <= 5; t++) fill_step(64'(t), 64'h100 + 64'(t));
      lookup_step(64'd1, 64'd0);
      for (int t = 2; t <= 5; t++) lookup_step(64'(t), 64'h100 + 64'(t));
      fill_step(64'd3, 64'hCC);
      fill_step(64'd6, 64'h106);
      lookup_step(64'd3, 64'hCC);
      lookup_step(64'd2, 64'd0);
      lookup_step(64'd6, 64'h106);
      fill_step(64'd7, 64'd0);
      fill_step(64'd5, 64'd0);
      fill_step(64'd8, 64'h108);
      lookup_step(64'd3, 64'd0);
      lookup_step(64'd4, 64'h104);
      lookup_step(64'd5, 64'h105);
      lookup_step(64'd7, 64'd0);
      lookup_step(64'd8, 64'h108);
   endtask

   task automatic test_same_cycle_fill();
      fill(64'h30, 64'h330);
      issue(64'h30, 1'b0, 64'd0, 1'b0);
      step();
      lookup_step(64'h30, 64'h330);
   endtask

   task automatic test_flush();
      flush_step();
      fill_step(64'h10, 64'hAB);
      fill(64'h40, 64'h440);
      issue(64'h10, 1'b0, 64'hAB, 1'b0);
      flush_step();
      lookup_step(64'h10, 64'd0);
      lookup_step(64'h40, 64'd0);
      lookup_step(64'h30, 64'd0);
      for (int t = 'h51; t <= 'h55; t++) fill_step(64'(t), 64'h1000 + 64'(t));
      lookup_step(64'h51, 64'd0);
      lookup_step(64'h52, 64'h1052);
   endtask

   task automatic test_write_error();
      issue(64'h53, 1'b1, 64'd0, 1'b1);
      step();
      check_stats("stats_after_write");
      lookup_step(64'h53, 64'h1053);
      issue(64'h60, 1'b1, 64'd0, 1'b1);
      step();
      lookup_step(64'h60, 64'd0);
      check_stats("stats_after_lookups");
   endtask

   task automatic test_back_to_back();
      logic [63:0] tags [8];
      logic [63:0] exps [8];
      tags = '{64'h52, 64'h53, 64'h99, 64'h54, 64'h55, 64'h51, 64'h52, 64'h55};
      exps = '{64'h1052, 64'h1053, 64'd0, 64'h1054, 64'h1055, 64'd0, 64'h1052, 64'h1055};
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 8; i++) begin
            int k;
            k = (i + r * 3) % 8;
            lookup_step(tags[k], exps[k]);
         end
      end
      check_stats("stats_back_to_back");
   endtask

   task automatic test_flush_inflight();
      issue(64'h54, 1'b0, 64'h1054, 1'b0);
      step();
      issue(64'h54, 1'b0, 64'h1054, 1'b0);
      flush_step();
      lookup_step(64'h54, 64'd0);
   endtask

   task automatic test_reset_drop();
      fill_step(64'h70, 64'h770);
      req  = 1'b1;
      addr = 64'h70;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      req   = 1'b0;
      exp_hits   = 0;
      exp_misses = 0;
      #1;
      vectors++;
      if (valid !== 1'b0 || rdata !== 64'd0) begin
         miscompares++;
         $display("FAIL reset_drop: got valid=%b rdata=%h, want 0 0", valid, rdata);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      lookup_step(64'h70, 64'd0);
      check_stats("stats_after_reset");
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      staged_v    = 1'b0;
      exp_hits    = 0;
      exp_misses  = 0;
      rst_n       = 1'b0;
      req         = 1'b0;
      we          = 1'b0;
      addr        = '0;
      wdata       = '0;
      be          = 8'hFF;
      fill_valid  = 1'b0;
      fill_tag    = '0;
      fill_data   = '0;
      flush       = 1'b0;

      test_reset();
      test_miss_empty();
      test_hit();
      test_round_robin();
      test_same_cycle_fill();
      test_flush();
      test_write_error();
      test_back_to_back();
      test_flush_inflight();
      test_reset_drop();

      step();
      step();
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d responses outstanding, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
